// File: rtl/rns_forward_converter.sv
// rns_forward_converter: iterative binary-to-RNS converter for moduli {2^n-1, 2^n+1, 2^2n+1, 2^(2n+p)}
module rns_forward_converter #(
    parameter int n = 20,
    parameter int p = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*n+p-1:0]     X,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n-1:0]         R1,
    output logic [n:0]           R2,
    output logic [2*n:0]         R3,
    output logic [2*n+p-1:0]     R4
);
    localparam int W  = 6*n+p;
    localparam int C  = (W+n-1)/n;
    localparam int CW = $clog2(C);
    localparam logic [n+1:0]   M2 = {1'b0, 1'b1, {(n-1){1'b0}}, 1'b1};
    localparam logic [2*n+1:0] M3 = {1'b0, 1'b1, {(2*n-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, FOLD, OUT} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [C*n-1:0]     xs_q, xs_d;
    logic [n-1:0]       a1_q, a1_d, r1_q, r1_d;
    logic [n:0]         a2_q, a2_d, r2_q, r2_d;
    logic [2*n:0]       a3_q, a3_d, r3_q, r3_d;
    logic [2*n+p-1:0]   r4_q, r4_d;
    logic               out_valid_q, out_valid_d;
    logic [n-1:0]       chunk, t1, f1;
    logic [n:0]         s1;
    logic [n+1:0]       s2, f2;
    logic [2*n-1:0]     w3;
    logic [2*n+1:0]     s3, f3;

    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign R1 = r1_q;
    assign R2 = r2_q;
    assign R3 = r3_q;
    assign R4 = r4_q;

    // Fold the low chunk into each accumulator with its weight 2^(n*cnt) mod m_i, keeping results canonical
    always_comb begin
        chunk = xs_q[n-1:0];
        s1 = {1'b0, a1_q} + {1'b0, chunk};
        t1 = s1[n-1:0] + {{(n-1){1'b0}}, s1[n]};
        f1 = &t1 ? '0 : t1;
        s2 = {1'b0, a2_q} + (cnt_q[0] ? M2 - {2'b0, chunk} : {2'b0, chunk});
        f2 = s2 >= M2 ? s2 - M2 : s2;
        w3 = cnt_q[0] ? {chunk, {n{1'b0}}} : {{n{1'b0}}, chunk};
        s3 = {1'b0, a3_q} + (cnt_q[1] ? M3 - {2'b0, w3} : {2'b0, w3});
        f3 = s3 >= M3 ? s3 - M3 : s3;
    end

    // Next state: accept in IDLE, fold one chunk per cycle, then register and hold results in OUT
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xs_d        = xs_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        r4_d        = r4_q;
        out_valid_d = out_valid_q;
        if (state_q == IDLE && in_valid) begin
            state_d      = FOLD;
            cnt_d        = '0;
            xs_d         = '0;
            xs_d[W-1:0]  = X;
            a1_d         = '0;
            a2_d         = '0;
            a3_d         = '0;
            r4_d         = X[2*n+p-1:0];
        end else if (state_q == FOLD) begin
            xs_d  = xs_q >> n;
            a1_d  = f1;
            a2_d  = f2[n:0];
            a3_d  = f3[2*n:0];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(C-1)) state_d = OUT;
        end else if (state_q == OUT) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                r1_d        = a1_q;
                r2_d        = a2_q;
                r3_d        = a3_q;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            xs_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            r4_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xs_q        <= xs_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            r4_q        <= r4_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_rns_forward_converter.sv
// tb_rns_forward_converter: scoreboard bench for the binary-to-RNS forward converter
module tb_rns_forward_converter;
    localparam int N = 20;
    localparam int P = 7;
    localparam int W = 6*N+P;

    typedef struct packed {
        logic [N-1:0]     r1;
        logic [N:0]       r2;
        logic [2*N:0]     r3;
        logic [2*N+P-1:0] r4;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       X = '0;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       R1;
    logic [N:0]         R2;
    logic [2*N:0]       R3;
    logic [2*N+P-1:0]   R4;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    bit   bp_en = 1'b0;
    bit   ready_force = 1'b1;

    rns_forward_converter #(.n(N), .p(P)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .X(X),
        .out_valid(out_valid), .out_ready(out_ready),
        .R1(R1), .R2(R2), .R3(R3), .R4(R4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x);
        logic [127:0] xx;
        exp_t e;
        xx   = 128'(x);
        e.r1 = N'(xx % ((128'd1 << N) - 1));
        e.r2 = (N+1)'(xx % ((128'd1 << N) + 1));
        e.r3 = (2*N+1)'(xx % ((128'd1 << (2*N)) + 1));
        e.r4 = x[2*N+P-1:0];
        return e;
    endfunction

    // Sole driver of out_ready: forced level or random backpressure
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Monitor: every valid cycle is compared against the queue head; the head retires on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got out_valid 1 expected no pending result");
            end else begin
                check("R1", 64'(R1), 64'(q[0].r1));
                check("R2", 64'(R2), 64'(q[0].r2));
                check("R3", 64'(R3), 64'(q[0].r3));
                check("R4", 64'(R4), 64'(q[0].r4));
                check("in_ready_in_out", 64'(in_ready), 64'd0);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] x, input bit push, input exp_t e);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("accept_wait", 64'(in_ready), 64'd1);
        X = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        X = ~x;
        if (push) q.push_back(e);
    endtask

    task automatic run_vec(input logic [127:0] x, input logic [127:0] r1, input logic [127:0] r2,
                           input logic [127:0] r3, input logic [127:0] r4);
        exp_t e;
        e.r1 = N'(r1);
        e.r2 = (N+1)'(r2);
        e.r3 = (2*N+1)'(r3);
        e.r4 = (2*N+P)'(r4);
        send(W'(x), 1'b1, e);
    endtask

    task automatic drain();
        int k = 0;
        while ((q.size() != 0 || out_valid) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int k;
        exp_t e;
        logic [127:0] rx;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_R1", 64'(R1), 64'd0);
        check("reset_R4", 64'(R4), 64'd0);

        // Zero operand plus latency: out_valid must first appear C+1 edges after accept
        run_vec(128'd0, 0, 0, 0, 0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 64'(k), 64'd8);

        run_vec((128'd1 << 20) - 1, 0, (128'd1 << 20) - 1, (128'd1 << 20) - 1, (128'd1 << 20) - 1);
        run_vec(128'd1 << 47, 128, 128, (128'd1 << 40) - 127, 0);
        run_vec((128'd1 << 127) - (128'd1 << 47) - 1, (128'd1 << 20) - 2, 128'd1 << 20,
                128'd1 << 40, (128'd1 << 47) - 1);
        run_vec(128'd1, 1, 1, 1, 1);
        run_vec(128'd1 << 20, 1, 128'd1 << 20, 128'd1 << 20, 128'd1 << 20);
        run_vec(128'd1 << 60, 1, 128'd1 << 20, (128'd1 << 40) - (128'd1 << 20) + 1, 0);
        run_vec((128'd1 << 127) - 1, 127, 127, (128'd1 << 40) - 128, (128'd1 << 47) - 1);
        drain();

        // Backpressure: hold out_ready low for 5 valid cycles, then complete the handshake
        ready_force = 1'b0;
        run_vec(128'd12345, 12345, 12345, 12345, 12345);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(out_valid), 64'd1);
        end
        ready_force = 1'b1;
        k = 0;
        while (out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("post_handshake_valid", 64'(out_valid), 64'd0);
        check("post_handshake_ready", 64'(in_ready), 64'd1);

        // Random operands with random backpressure, checked against a modulo model
        bp_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx = {$urandom, $urandom, $urandom, $urandom};
            e  = model(W'(rx));
            send(W'(rx), 1'b1, e);
        end
        drain();
        bp_en = 1'b0;
        ready_force = 1'b1;
        @(posedge clk);
        #1;

        // Reset while folding chunk 3 aborts the conversion
        e = model(W'(128'h1_2345_6789));
        send(W'(128'h1_2345_6789), 1'b0, e);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_R1", 64'(R1), 64'd0);
        check("abort_R2", 64'(R2), 64'd0);
        check("abort_R3", 64'(R3), 64'd0);
        check("abort_R4", 64'(R4), 64'd0);
        rst = 1'b0;
        k = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) k++;
        end
        check("abort_no_output", 64'(k), 64'd0);

        run_vec(128'd1 << 47, 128, 128, (128'd1 << 40) - 127, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
